// File: rtl/pin_frame_tx.sv
// pin_frame_tx: byte FIFO feeding a serial framer (start, 8 data LSB first, stop).
// Define PIN_FRAME_TX_PARITY_EN to insert an even parity bit before STOP.
module pin_frame_tx #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       tx,
  output logic       busy,
  output logic [3:0] fifo_count,
  output logic       overflow
);

  localparam int            PW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    FULL_CNT = 4'(FIFO_DEPTH);
  localparam logic [7:0]    BAUD_MAX = 8'(CLKS_PER_BIT - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [3:0]    r_count;
  logic          r_overflow;
  logic [2:0]    r_state;
  logic [7:0]    r_baud;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef PIN_FRAME_TX_PARITY_EN
  logic          r_parity;
`endif

  logic w_ready;
  logic w_fifo_empty;
  logic w_push;
  logic w_pop;
  logic w_bit_end;

  assign w_ready      = (r_count != FULL_CNT);
  assign w_fifo_empty = (r_count == 4'd0);
  assign w_push       = valid_in && w_ready;
  assign w_bit_end    = (r_baud == BAUD_MAX);
  // The head byte leaves the FIFO either from IDLE or at the last STOP cycle,
  // which is what keeps consecutive frames gap-free.
  assign w_pop        = !w_fifo_empty && ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 4'd0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_IDX) ? '0 : r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 4'd1;
        2'b01:   r_count <= r_count - 4'd1;
        default: r_count <= r_count;
      endcase
      if (valid_in && !w_ready) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_baud    <= 8'd0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
`ifdef PIN_FRAME_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      if (r_state != IDLE) begin
        r_baud <= w_bit_end ? 8'd0 : r_baud + 8'd1;
      end
      if (w_pop) begin
        r_shift   <= r_mem[r_rd_ptr];
`ifdef PIN_FRAME_TX_PARITY_EN
        r_parity  <= ^r_mem[r_rd_ptr];
`endif
        r_baud    <= 8'd0;
        r_bit_idx <= 3'd0;
        r_state   <= START;
      end else begin
        case (r_state)
          START: begin
            if (w_bit_end) r_state <= DATA;
          end
          DATA: begin
            if (w_bit_end) begin
              r_shift   <= {1'b0, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
`ifdef PIN_FRAME_TX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end
          end
          PARITY: begin
            if (w_bit_end) r_state <= STOP;
          end
          STOP: begin
            if (w_bit_end) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // tx follows the state one cycle late, so the line stays glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx <= 1'b1;
    end else begin
      case (r_state)
        START:   r_tx <= 1'b0;
        DATA:    r_tx <= r_shift[0];
`ifdef PIN_FRAME_TX_PARITY_EN
        PARITY:  r_tx <= r_parity;
`endif
        default: r_tx <= 1'b1;
      endcase
    end
  end

  assign ready_out  = w_ready;
  assign tx         = r_tx;
  assign busy       = (r_state != IDLE) || !w_fifo_empty;
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pin_frame_tx.sv
// Testbench for pin_frame_tx: frame-level timeline model plus a line decoder.
module tb_pin_frame_tx;

  localparam int C     = 8;
  localparam int DEPTH = 4;
`ifdef PIN_FRAME_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif
  localparam int FB    = 10 + PAR_EN;
  localparam int FRAME = FB * C;

  typedef logic [7:0] byteq_t[$];
  typedef struct {
    int         start;
    logic [7:0] b;
  } frame_t;
  typedef struct {
    int         atEdge;
    logic       valid;
    logic [7:0] data;
    logic       expTx;
    logic [3:0] expCount;
    logic       expBusy;
    logic       expReady;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       tx;
  logic       busy;
  logic [3:0] fifo_count;
  logic       overflow;

  always #5 clk = ~clk;

  pin_frame_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_out), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .overflow(overflow)
  );

  int checks = 0;
  int failures = 0;
  int edgeNum = 0;
  int peakCount = 0;

  // Model: each accepted byte gets a scheduled tx start edge; line state is derived from that list.
  frame_t frames[$];
  int     lineFreeAt = 0;
  logic   modelOvf = 1'b0;
  byteq_t sentQ;
  byteq_t rxQ;

  logic       rxActive = 1'b0;
  int         rxCnt = 0;
  logic [7:0] rxByte = 8'h00;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeNum);
    end
  endtask

  function automatic int modelCount(input int e);
    int n = 0;
    foreach (frames[i]) if (frames[i].start > e + 1) n++;
    return n;
  endfunction

  function automatic logic modelTx(input int e);
    foreach (frames[i]) begin
      if (e >= frames[i].start && e < frames[i].start + FRAME) begin
        int k = (e - frames[i].start) / C;
        if (k == 0) return 1'b0;
        if (k <= 8) return frames[i].b[k-1];
        if (PAR_EN == 1 && k == 9) return ^frames[i].b;
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  function automatic logic modelBusy(input int e);
    foreach (frames[i]) if (e < frames[i].start - 1 + FRAME) return 1'b1;
    return 1'b0;
  endfunction

  task automatic decodeSample(input logic t);
    int k;
    if (!rxActive) begin
      if (t == 1'b0) begin
        rxActive = 1'b1;
        rxCnt = 0;
      end
    end else begin
      rxCnt++;
      if (rxCnt % C == C / 2) begin
        k = rxCnt / C;
        if (k == 0) begin
          checkOutput("rxStart", t, 0);
        end else if (k <= 8) begin
          rxByte[k-1] = t;
`ifdef PIN_FRAME_TX_PARITY_EN
        end else if (k == 9) begin
          checkOutput("rxParity", t, ^rxByte);
`endif
        end else begin
          checkOutput("rxStop", t, 1);
          rxQ.push_back(rxByte);
          rxActive = 1'b0;
        end
      end
    end
  endtask

  // One clock: drive at negedge, model the posedge, compare at the next negedge.
  task automatic applyStimulus(input logic v, input logic [7:0] d);
    int cntBefore;
    int st;
    valid_in = v;
    data_in  = d;
    @(posedge clk);
    edgeNum++;
    while (frames.size() > 0 && frames[0].start + FRAME <= edgeNum - 1) void'(frames.pop_front());
    cntBefore = modelCount(edgeNum - 1);
    if (v) begin
      if (cntBefore < DEPTH) begin
        st = (edgeNum + 2 > lineFreeAt) ? edgeNum + 2 : lineFreeAt;
        frames.push_back('{st, d});
        lineFreeAt = st + FRAME;
        sentQ.push_back(d);
      end else begin
        modelOvf = 1'b1;
      end
    end
    @(negedge clk);
    checkOutput("modelTx", tx, modelTx(edgeNum));
    checkOutput("modelCount", fifo_count, modelCount(edgeNum));
    checkOutput("modelReady", ready_out, modelCount(edgeNum) < DEPTH);
    checkOutput("modelBusy", busy, modelBusy(edgeNum));
    checkOutput("modelOverflow", overflow, modelOvf);
    if (int'(fifo_count) > peakCount) peakCount = int'(fifo_count);
    decodeSample(tx);
  endtask

  task automatic clearModel();
    frames.delete();
    sentQ.delete();
    rxQ.delete();
    lineFreeAt = 0;
    modelOvf = 1'b0;
    rxActive = 1'b0;
    peakCount = 0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_tx"}, tx, 1);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_count"}, fifo_count, 0);
    checkOutput({tag, "_ready"}, ready_out, 1);
    checkOutput({tag, "_overflow"}, overflow, 0);
  endtask

  task automatic doReset();
    @(negedge clk);
    valid_in = 1'b0;
    data_in  = 8'h00;
    rst = 1'b1;
    #1;
    checkResetValues("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetValues("resetHeld");
    rst = 1'b0;
    clearModel();
  endtask

  task automatic drainLine();
    int budget = (DEPTH + 2) * FRAME + 20;
    int i = 0;
    while (i < budget && (busy || rxActive)) begin
      applyStimulus(1'b0, 8'h00);
      i++;
    end
    checkOutput("drainTimeout", busy | rxActive, 0);
    repeat (3) applyStimulus(1'b0, 8'h00);
  endtask

  task automatic compareBytes(input string name, input byteq_t got, input byteq_t exp);
    checkOutput({name, "_size"}, got.size(), exp.size());
    foreach (exp[i]) begin
      if (i < got.size()) checkOutput($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t   vecs[$];
    byteq_t exp;
    int     base;
    logic [7:0] b;
    logic [7:0] parBytes[2];

    rst = 1'b1;
    valid_in = 1'b0;
    data_in = 8'h00;
    vecs.push_back('{0,  1'b1, 8'hA5, 1'b1, 4'd1, 1'b1, 1'b1});
    vecs.push_back('{1,  1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{2,  1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{9,  1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{10, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{18, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{26, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{34, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{42, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{50, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{58, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{66, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
`ifdef PIN_FRAME_TX_PARITY_EN
    vecs.push_back('{74, 1'b0, 8'h00, 1'b0, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{82, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
`else
    vecs.push_back('{74, 1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
`endif
    vecs.push_back('{FRAME,     1'b0, 8'h00, 1'b1, 4'd0, 1'b1, 1'b1});
    vecs.push_back('{FRAME + 1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 1'b1});

    doReset();

    // Single 0xA5 frame against a hand-computed waveform table.
    base = edgeNum;
    foreach (vecs[i]) begin
      while (edgeNum < base + vecs[i].atEdge) applyStimulus(1'b0, 8'h00);
      applyStimulus(vecs[i].valid, vecs[i].data);
      checkOutput($sformatf("vecTx[%0d]", i), tx, vecs[i].expTx);
      checkOutput($sformatf("vecCount[%0d]", i), fifo_count, vecs[i].expCount);
      checkOutput($sformatf("vecBusy[%0d]", i), busy, vecs[i].expBusy);
      checkOutput($sformatf("vecReady[%0d]", i), ready_out, vecs[i].expReady);
    end
    drainLine();
    exp = '{8'hA5};
    compareBytes("singleA5", rxQ, exp);

    // Back-to-back frames from consecutive pushes.
    rxQ.delete();
    peakCount = 0;
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h3C);
    drainLine();
    checkOutput("b2bPeakCount", peakCount, 2);
    exp = '{8'h00, 8'hFF, 8'h3C};
    compareBytes("b2b", rxQ, exp);

    // Overflow: six consecutive offers, the sixth must be dropped.
    rxQ.delete();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'h11 + 8'(i));
      if (i == 4) begin
        checkOutput("ovfFullCount", fifo_count, 4);
        checkOutput("ovfFullReady", ready_out, 0);
        checkOutput("ovfNotYet", overflow, 0);
      end
    end
    checkOutput("ovfFlag", overflow, 1);
    drainLine();
    checkOutput("ovfSticky", overflow, 1);
    exp = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    compareBytes("ovfFrames", rxQ, exp);
    doReset();

    // Parity slot: parity bit when enabled, otherwise the stop bit.
    parBytes[0] = 8'h07;
    parBytes[1] = 8'h03;
    for (int j = 0; j < 2; j++) begin
      base = edgeNum;
      applyStimulus(1'b1, parBytes[j]);
      while (edgeNum < base + 1 + 2 + 9 * C + C / 2) applyStimulus(1'b0, 8'h00);
`ifdef PIN_FRAME_TX_PARITY_EN
      checkOutput($sformatf("paritySlot%0d", j), tx, (j == 0) ? 1 : 0);
`else
      checkOutput($sformatf("stopAfterBit7_%0d", j), tx, 1);
`endif
      drainLine();
    end

    // Pointer wrap: ten isolated frames.
    rxQ.delete();
    sentQ.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      exp.push_back(b);
      applyStimulus(1'b1, b);
      repeat (FRAME + 2) applyStimulus(1'b0, 8'h00);
    end
    exp = exp[exp.size()-10:exp.size()-1];
    compareBytes("wrap", rxQ, exp);

    // Reset in the middle of DATA bit 3 of 0x5A with another byte queued.
    base = edgeNum;
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b1, 8'h77);
    while (edgeNum < base + 1 + 2 + 4 * C + 3) applyStimulus(1'b0, 8'h00);
    #2 rst = 1'b1;
    #1;
    checkResetValues("midReset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    clearModel();
    repeat (2 * FRAME) applyStimulus(1'b0, 8'h00);
    checkOutput("midResetNoResume", rxQ.size(), 0);
    checkOutput("midResetCount", fifo_count, 0);

    // Randomized traffic in bursts of varying density.
    doReset();
    begin
      int pct = 50;
      for (int i = 0; i < 1500; i++) begin
        if (i % 100 == 0) pct = $urandom_range(0, 100);
        applyStimulus(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0, 8'($urandom_range(0, 255)));
      end
    end
    drainLine();
    compareBytes("random", rxQ, sentQ);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pin_frame_tx.md
PIN_FRAME_TX -- requirements
Module: pin_frame_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 8; clock cycles per serial bit; legal range 2..255.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4; byte entries buffered ahead of the serializer; power of two, 2..8.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_in  input  8  byte to transmit.
REQ-006 SHALL have port valid_in  input  1  data_in is offered this cycle.
REQ-007 SHALL have port ready_out  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  serial line; idle high.
REQ-009 SHALL have port busy  output  1  a frame is being shifted or the FIFO is non-empty.
REQ-010 SHALL have port fifo_count  output  4  current FIFO occupancy, 0..FIFO_DEPTH.
REQ-011 SHALL have port overflow  output  1  sticky flag; a byte was offered while the FIFO was full.

Function
REQ-012 SHALL accept a byte on a rising edge where valid_in=1 and ready_out=1; ready_out = (fifo_count != FIFO_DEPTH).
REQ-013 SHALL discard a byte offered with valid_in=1 while ready_out=0, leave the FIFO unchanged and set overflow on that edge.
REQ-014 SHALL implement the FIFO as a circular buffer; read and write pointers wrap from FIFO_DEPTH-1 to 0.
REQ-015 SHALL, on a simultaneous push and pop, keep fifo_count unchanged, including when the FIFO is full (ready_out is still 0 when full, so no push occurs then).
REQ-016 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-017 SHALL, in IDLE with the FIFO non-empty, pop the head byte into the shift register and enter START on the same edge.
REQ-018 SHALL hold each of START, each DATA bit, PARITY and STOP for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at each bit boundary.
REQ-019 SHALL drive tx=0 in START, data bits LSB first in DATA, the parity bit in PARITY, and tx=1 in STOP and IDLE.
REQ-020 SHALL, at the end of STOP, pop the next byte and re-enter START directly if the FIFO is non-empty (no idle gap between frames); otherwise it SHALL enter IDLE.
REQ-021 SHALL register tx, so the first START cycle appears on tx one cycle after the pop edge; latency from accept to the tx falling edge with an empty FIFO and IDLE state = 2 cycles.
REQ-022 SHALL assert busy whenever the state is not IDLE or fifo_count != 0.
REQ-023 SHALL keep the bit counter 3 bits wide; DATA exits after bit index 7.

Reset
REQ-024 SHALL, while rst=1, force state=IDLE, tx=1, busy=0, fifo_count=0, pointers=0, overflow=0, ready_out=1, and clear the baud and bit counters.
REQ-025 SHALL, if reset is asserted mid-frame, return tx to 1 immediately and discard both the partial frame and the FIFO contents; no frame resumes after release.
REQ-026 SHALL clear overflow only by reset.

Configuration
REQ-027 SHALL use the macro PIN_FRAME_TX_PARITY_EN: when defined, the frame is start + 8 data + even parity + stop (11 bits), and PARITY drives the XOR of the 8 data bits.
REQ-028 SHALL, when PIN_FRAME_TX_PARITY_EN is undefined, skip PARITY so the frame is 10 bits (DATA goes directly to STOP); all other behaviour is unchanged.

Verification
REQ-029 SHALL cover the single-byte case: CLKS_PER_BIT=8, push 0xA5 -> tx low for cycles 2..9 after accept, then bits 1,0,1,0,0,1,0,1, (parity 0 if enabled), then high; busy drops after 80 (88) cycles.
REQ-030 SHALL cover back-to-back frames: push 0x00, 0xFF, 0x3C on consecutive cycles -> three frames with no idle bits between STOP and the next START; fifo_count peaks at 2.
REQ-031 SHALL cover overflow: hold valid_in=1 with 0x11..0x16 while the first frame is shifting -> 0x11 goes to the serializer, 0x12..0x15 are queued (fifo_count=4, ready_out=0), 0x16 is dropped, overflow=1; exactly 5 frames appear on tx.
REQ-032 SHALL cover reset mid-frame: assert rst during DATA bit 3 of 0x5A -> tx=1 the same cycle; after release tx stays 1 and fifo_count=0.
REQ-033 SHALL cover parity: with PIN_FRAME_TX_PARITY_EN defined, 0x07 -> parity bit 1 and 0x03 -> parity bit 0; with the macro undefined, the STOP bit follows data bit 7.
REQ-034 SHALL cover pointer wrap: 10 single pushes spaced one frame apart -> every byte is transmitted intact and in order.
